// File: rtl/run_monitor.sv
// run_monitor: run controller placed beside the single-cycle MIPS CPU.
// Watches retired PCs and halts the CPU on an instruction-count limit, a
// self-loop (the same PC retiring repeatedly) or a PC outside the text window.
// Once halted it streams one dump beat per cycle: every register, then a
// window of data-memory words, and finally raises a sticky done.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   retire, pc   retired-instruction strobe and its PC
//   halt         freeze request to the CPU (PC/RF/DM writes)
//   rf_raddr     register-file dump read address   / rf_rdata its data
//   dm_raddr     data-memory dump byte address     / dm_rdata its data
//   dump_valid, dump_kind (0 reg, 1 mem), dump_index, dump_data: dump beat
//   done         dump complete, sticky until reset
//   halt_cause   00 none, 01 count limit, 10 self-loop, 11 bad PC
//   inst_count   retired instruction count (saturating)
module run_monitor #(
  parameter int unsigned MAX_INST    = 40,
  parameter int unsigned LOOP_THRESH = 4,
  parameter logic [31:0] TEXT_BASE   = 32'h0000_3000,
  parameter int unsigned TEXT_WORDS  = 1024,
  parameter int unsigned REG_NUM     = 32,
  parameter logic [31:0] DUMP_BASE   = 32'd80,
  parameter int unsigned DUMP_WORDS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic [31:0] pc,
  output logic        halt,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] dm_raddr,
  input  logic [31:0] dm_rdata,
  output logic        dump_valid,
  output logic        dump_kind,
  output logic [7:0]  dump_index,
  output logic [31:0] dump_data,
  output logic        done,
  output logic [1:0]  halt_cause,
  output logic [31:0] inst_count
);

  typedef enum logic [1:0] {S_RUN, S_DUMP_RF, S_DUMP_DM, S_DONE} state_t;

  // 33-bit end address so a window reaching the top of memory cannot wrap
  localparam logic [32:0] TEXT_END = {1'b0, TEXT_BASE} + 33'(TEXT_WORDS) * 33'd4;
  localparam logic [7:0]  RF_LAST  = 8'(REG_NUM - 1);
  localparam logic [7:0]  DM_LAST  = 8'(DUMP_WORDS - 1);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] loop_cnt_q, loop_cnt_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        last_vld_q, last_vld_d;
  logic [1:0]  cause_q, cause_d;
  logic [4:0]  rf_raddr_q, rf_raddr_d;
  logic [31:0] dm_raddr_q, dm_raddr_d;

  logic [31:0] new_count;
  logic [31:0] new_loop;
  logic        bad_pc;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    inst_count_d = inst_count_q;
    loop_cnt_d   = loop_cnt_q;
    last_pc_d    = last_pc_q;
    last_vld_d   = last_vld_q;
    cause_d      = cause_q;
    rf_raddr_d   = 5'd0;
    dm_raddr_d   = 32'd0;

    new_count = (inst_count_q == 32'hFFFF_FFFF) ? inst_count_q : inst_count_q + 32'd1;
    // last_vld keeps the very first retire from matching the reset value of last_pc
    new_loop  = (last_vld_q && (pc == last_pc_q)) ? loop_cnt_q + 32'd1 : 32'd0;
    bad_pc    = ({1'b0, pc} < {1'b0, TEXT_BASE}) || ({1'b0, pc} >= TEXT_END) ||
                (pc[1:0] != 2'b00);

    case (state_q)
      S_RUN: begin
        if (retire) begin
          inst_count_d = new_count;
          loop_cnt_d   = new_loop;
          last_pc_d    = pc;
          last_vld_d   = 1'b1;
          if (bad_pc)
            cause_d = 2'b11;
          else if ((MAX_INST != 0) && (new_count == 32'(MAX_INST)))
            cause_d = 2'b01;
          else if (new_loop == 32'(LOOP_THRESH))
            cause_d = 2'b10;
          if (cause_d != 2'b00) begin
            state_d = S_DUMP_RF;
            idx_d   = 8'd0;
          end
        end
      end
      S_DUMP_RF: begin
        if (idx_q == RF_LAST) begin
          idx_d = 8'd0;
          if (DUMP_WORDS == 0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_DUMP_DM;
            dm_raddr_d = DUMP_BASE;
          end
        end else begin
          idx_d      = idx_q + 8'd1;
          rf_raddr_d = 5'(idx_q + 8'd1);
        end
      end
      S_DUMP_DM: begin
        if (idx_q == DM_LAST) begin
          state_d = S_DONE;
          idx_d   = 8'd0;
        end else begin
          idx_d      = idx_q + 8'd1;
          dm_raddr_d = dm_raddr_q + 32'd4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      idx_q        <= 8'd0;
      inst_count_q <= 32'd0;
      loop_cnt_q   <= 32'd0;
      last_pc_q    <= 32'd0;
      last_vld_q   <= 1'b0;
      cause_q      <= 2'b00;
      rf_raddr_q   <= 5'd0;
      dm_raddr_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      inst_count_q <= inst_count_d;
      loop_cnt_q   <= loop_cnt_d;
      last_pc_q    <= last_pc_d;
      last_vld_q   <= last_vld_d;
      cause_q      <= cause_d;
      rf_raddr_q   <= rf_raddr_d;
      dm_raddr_q   <= dm_raddr_d;
    end
  end

  // Outputs decode from registered state only, so reset zeroes them at once.
  always_comb begin
    halt       = (state_q != S_RUN);
    done       = (state_q == S_DONE);
    dump_valid = (state_q == S_DUMP_RF) || (state_q == S_DUMP_DM);
    dump_kind  = (state_q == S_DUMP_DM);
    dump_index = dump_valid ? idx_q : 8'd0;
    dump_data  = 32'd0;
    if (state_q == S_DUMP_RF)
      dump_data = (idx_q == 8'd0) ? 32'd0 : rf_rdata;  // $zero reads as 0
    else if (state_q == S_DUMP_DM)
      dump_data = dm_rdata;
    rf_raddr   = rf_raddr_q;
    dm_raddr   = dm_raddr_q;
    halt_cause = cause_q;
    inst_count = inst_count_q;
  end

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        halt, dump_valid, dump_kind, done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata, dm_raddr, dm_rdata, dump_data, inst_count;
  logic [7:0]  dump_index;
  logic [1:0]  halt_cause;

  logic        retire0 = 1'b0;
  logic [31:0] pc0 = 32'd0;
  logic        halt0, dump_valid0, dump_kind0, done0;
  logic [4:0]  rf_raddr0;
  logic [31:0] dm_raddr0, dump_data0, inst_count0;
  logic [7:0]  dump_index0;
  logic [1:0]  halt_cause0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [31:0] a);
    return (a == 32'd0) ? 32'hDEAD_BEEF : 32'h1000_0000 + a * 32'h0101;
  endfunction

  function automatic logic [31:0] dm_val(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign rf_rdata = rf_val({27'd0, rf_raddr});
  assign dm_rdata = dm_val(dm_raddr);

  run_monitor dut (
    .clk(clk), .rst(rst), .retire(retire), .pc(pc), .halt(halt),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .dump_valid(dump_valid), .dump_kind(dump_kind), .dump_index(dump_index),
    .dump_data(dump_data), .done(done), .halt_cause(halt_cause), .inst_count(inst_count)
  );

  run_monitor #(.MAX_INST(0)) dut0 (
    .clk(clk), .rst(rst), .retire(retire0), .pc(pc0), .halt(halt0),
    .rf_raddr(rf_raddr0), .rf_rdata(32'd0), .dm_raddr(dm_raddr0), .dm_rdata(32'd0),
    .dump_valid(dump_valid0), .dump_kind(dump_kind0), .dump_index(dump_index0),
    .dump_data(dump_data0), .done(done0), .halt_cause(halt_cause0), .inst_count(inst_count0)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a history of retired PCs plus a beat counter after halt.
  logic [31:0] m_hist[$];
  int unsigned m_count = 0;
  bit          m_halted = 0;
  logic [1:0]  m_cause = 2'b00;
  int          m_b = 0;

  always @(posedge clk or negedge rst) begin
    int rep;
    if (!rst) begin
      m_hist.delete();
      m_count  = 0;
      m_halted = 0;
      m_cause  = 2'b00;
      m_b      = 0;
    end else if (m_halted) begin
      if (m_b < 1000) m_b++;
    end else if (retire) begin
      if (m_count != 32'hFFFF_FFFF) m_count++;
      m_hist.push_back(pc);
      rep = 0;
      for (int j = m_hist.size() - 1; j > 0; j--) begin
        if (m_hist[j] != m_hist[j-1]) break;
        rep++;
      end
      if (pc < 32'h3000 || pc >= 32'h3000 + 4 * 1024 || pc % 4 != 0) m_cause = 2'b11;
      else if (m_count == 40)                                         m_cause = 2'b01;
      else if (rep == 4)                                              m_cause = 2'b10;
      if (m_cause != 2'b00) begin
        m_halted = 1;
        m_b      = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit e_valid, e_done;
    logic [31:0] e_rf, e_dm, e_data, e_idx;
    e_valid = m_halted && m_b < 34;
    e_done  = m_halted && m_b >= 34;
    e_rf    = (m_halted && m_b < 32) ? 32'(m_b) : 32'd0;
    e_dm    = (m_halted && m_b >= 32 && m_b < 34) ? 32'(80 + 4 * (m_b - 32)) : 32'd0;
    e_idx   = (m_b < 32) ? 32'(m_b) : 32'(m_b - 32);
    e_data  = (m_b < 32) ? ((m_b == 0) ? 32'd0 : rf_val(32'(m_b))) : dm_val(e_dm);
    chk("halt", {31'd0, halt}, {31'd0, m_halted});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("dump_valid", {31'd0, dump_valid}, {31'd0, e_valid});
    chk("rf_raddr", {27'd0, rf_raddr}, e_rf);
    chk("dm_raddr", dm_raddr, e_dm);
    chk("halt_cause", {30'd0, halt_cause}, {30'd0, m_cause});
    chk("inst_count", inst_count, m_count);
    if (e_valid) begin
      chk("dump_kind", {31'd0, dump_kind}, {31'd0, (m_b >= 32)});
      chk("dump_index", {24'd0, dump_index}, e_idx);
      chk("dump_data", dump_data, e_data);
    end
  end

  task automatic cyc(input logic r, input logic [31:0] p);
    retire = r;
    pc     = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    retire = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Distinct retires until halt; returns how many retires it took.
  task automatic run_until_halt(output int n);
    n = 0;
    while (!halt && n < 200) begin
      cyc(1'b1, 32'h3000 + 32'(4 * n));
      n++;
    end
  endtask

  // From the first halted cycle, step until done; retire stays high to show it is ignored.
  task automatic run_dump(output int beats, output int cycles, output logic [31:0] d0,
                          output logic [31:0] ma0, output logic [31:0] ma1);
    beats = 0; cycles = 0; d0 = 32'hFFFF_FFFF; ma0 = 32'd0; ma1 = 32'd0;
    while (!done && cycles < 100) begin
      if (dump_valid) begin
        beats++;
        if (!dump_kind && dump_index == 8'd0) d0 = dump_data;
        if (dump_kind && dump_index == 8'd0) ma0 = dm_raddr;
        if (dump_kind && dump_index == 8'd1) ma1 = dm_raddr;
      end
      cyc(1'b1, 32'h3000);
      cycles++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, beats, cycles, first_halt;
    logic [31:0] d0, ma0, ma1;
    logic [31:0] loop_pcs[7];

    #1;
    chk("reset_halt", {31'd0, halt}, 32'd0);
    chk("reset_count", inst_count, 32'd0);
    chk("reset_cause", {30'd0, halt_cause}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Count limit
    run_until_halt(n);
    chk("count_retires_to_halt", n, 40);
    chk("count_inst", inst_count, 40);
    chk("count_cause", {30'd0, halt_cause}, 32'd1);
    run_dump(beats, cycles, d0, ma0, ma1);
    chk("count_beats", beats, 34);
    chk("count_done_cycle", cycles, 34);
    chk("count_reg0_data", d0, 32'd0);
    chk("count_mem0_addr", ma0, 32'd80);
    chk("count_mem1_addr", ma1, 32'd84);
    chk("count_frozen", inst_count, 40);
    repeat (3) cyc(1'b1, 32'h3000);
    chk("done_sticky", {31'd0, done}, 32'd1);

    // Self-loop
    do_reset();
    loop_pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008, 32'h3008};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, loop_pcs[i]);
      if (i == 5) chk("loop_no_early_halt", {31'd0, halt}, 32'd0);
    end
    chk("loop_halt", {31'd0, halt}, 32'd1);
    chk("loop_inst", inst_count, 7);
    chk("loop_cause", {30'd0, halt_cause}, 32'd2);
    run_dump(beats, cycles, d0, ma0, ma1);

    // Bad PC below window
    do_reset();
    cyc(1'b1, 32'h2FFC);
    chk("badlo_cause", {30'd0, halt_cause}, 32'd3);
    chk("badlo_inst", inst_count, 1);

    // Misaligned PC
    do_reset();
    cyc(1'b1, 32'h3002);
    chk("misalign_cause", {30'd0, halt_cause}, 32'd3);

    // Bad PC on the 40th retire beats the count limit
    do_reset();
    for (int i = 0; i < 39; i++) cyc(1'b1, 32'h3000 + 32'(4 * i));
    chk("simul_no_halt", {31'd0, halt}, 32'd0);
    cyc(1'b1, 32'h4000 + 4 * 1024);
    chk("simul_cause", {30'd0, halt_cause}, 32'd3);
    chk("simul_inst", inst_count, 40);

    // Gapped retire
    do_reset();
    first_halt = -1;
    for (int c = 0; c < 80; c++) begin
      cyc((c % 2) == 0, 32'h3000 + 32'(4 * (c / 2)));
      if (halt && first_halt < 0) first_halt = c;
    end
    chk("gap_halt_cycle", first_halt, 78);
    chk("gap_inst", inst_count, 40);
    chk("gap_cause", {30'd0, halt_cause}, 32'd1);

    // Reset mid-dump
    do_reset();
    run_until_halt(n);
    n = 0;
    while (!(dump_valid && !dump_kind && dump_index == 8'd10) && n < 50) begin
      cyc(1'b0, 32'd0);
      n++;
    end
    chk("mid_reached_beat10", {24'd0, dump_index}, 32'd10);
    rst = 1'b0;
    #1;
    chk("mid_halt", {31'd0, halt}, 32'd0);
    chk("mid_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_rf_raddr", {27'd0, rf_raddr}, 32'd0);
    chk("mid_dm_raddr", dm_raddr, 32'd0);
    chk("mid_data", dump_data, 32'd0);
    chk("mid_count", inst_count, 32'd0);
    chk("mid_cause", {30'd0, halt_cause}, 32'd0);
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'd0);
      if (dump_valid) beats++;
    end
    chk("mid_no_beats", beats, 0);
    rst = 1'b1;
    run_until_halt(n);
    chk("rerun_retires", n, 40);
    run_dump(beats, cycles, d0, ma0, ma1);
    chk("rerun_beats", beats, 34);
    chk("rerun_reg0_data", d0, 32'd0);

    // Count limit disabled
    do_reset();
    for (int i = 0; i < 100; i++) begin
      retire0 = 1'b1;
      pc0     = 32'h3000 + 32'(4 * i);
      @(posedge clk);
      #1;
    end
    retire0 = 1'b0;
    chk("nolimit_halt", {31'd0, halt0}, 32'd0);
    chk("nolimit_inst", inst_count0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run controller for the single-cycle MIPS CPU. It replaces fixed instruction-count bench loops with parametrised halt detection: instruction-count limit, self-loop detection and an out-of-text-window PC trap. On halt it freezes the CPU and streams a beat-per-cycle dump of the register file and a configurable data-memory window. It sits beside `CPU`, observing the retired PC and using spare combinational read ports on the register file and data memory.

## Interface
- `MAX_INST`, 40: halt after this many retires; 0 disables the limit.
- `LOOP_THRESH`, 4: halt after this many consecutive retires whose PC equals the previous retired PC.
- `TEXT_BASE`, 32'h0000_3000: first legal instruction address.
- `TEXT_WORDS`, 1024: size of the text window in words.
- `REG_NUM`, 32: registers dumped.
- `DUMP_BASE`, 80: byte address of the first data-memory dump word.
- `DUMP_WORDS`, 2: number of data-memory words dumped.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `retire` in 1: one instruction retires this cycle.
- `pc` in 32: PC of the retiring instruction; valid when `retire`=1.
- `halt` out 1: freeze request to the CPU (gates PC/RF/DM writes).
- `rf_raddr` out 5: register-file dump read address.
- `rf_rdata` in 32: combinational read data for `rf_raddr`.
- `dm_raddr` out 32: data-memory dump byte address.
- `dm_rdata` in 32: combinational read data for `dm_raddr`.
- `dump_valid` out 1: dump beat valid.
- `dump_kind` out 1: 0 = register beat, 1 = memory beat.
- `dump_index` out 8: register number or memory word index.
- `dump_data` out 32: beat data.
- `done` out 1: dump complete; sticky until reset.
- `halt_cause` out 2: 00 none, 01 count limit, 10 self-loop, 11 bad PC.
- `inst_count` out 32: retired instruction count.

## Operation
- FSM states: RUN, DUMP_RF, DUMP_DM, DONE.
- **RUN:**
  - Each `retire` increments `inst_count`, which saturates at 32'hFFFF_FFFF.
  - `loop_cnt` resets to 0 on a retire whose PC differs from the last retired PC, and increments on a retire whose PC matches it.
  - Halt conditions are evaluated on the retiring beat, counting that beat. Priority:
    1. Bad PC: `pc` < TEXT_BASE, `pc` ≥ TEXT_BASE+4·TEXT_WORDS, or `pc[1:0]`≠0.
    2. Count limit: new count == MAX_INST and MAX_INST≠0.
    3. Self-loop: new `loop_cnt` == LOOP_THRESH.
  - On halt: latch `halt_cause`, set `halt`=1, go to DUMP_RF.
- **DUMP_RF:** one beat per cycle, index i = 0..REG_NUM-1.
  - `rf_raddr`=i, `dump_kind`=0, `dump_index`=i.
  - `dump_data`=`rf_rdata`, except i=0, which always emits 0.
  - After beat REG_NUM-1, go to DUMP_DM.
- **DUMP_DM:** beat j = 0..DUMP_WORDS-1.
  - `dm_raddr`=DUMP_BASE+4·j, `dump_kind`=1, `dump_index`=j, `dump_data`=`dm_rdata`.
  - After the last beat, go to DONE. If DUMP_WORDS=0, go directly from DUMP_RF to DONE.
- **DONE:** `done`=1, `halt`=1, `dump_valid`=0. Held until reset.
- `retire` is ignored outside RUN, so `inst_count` is frozen after halt.

## Timing
- Reset (`rst`=0) is asynchronous: all outputs are 0 immediately, and FSM, counters and cause are cleared to RUN/0.
- Reset mid-dump aborts the dump with no further beats; after release the block restarts in RUN.
- `halt` rises on the clock edge that samples the triggering retire. The first `dump_valid` beat (reg 0) is in the next cycle.
- Total dump = REG_NUM+DUMP_WORDS consecutive cycles with `dump_valid`=1 and no gaps. `done` rises the cycle after the last beat.
- `rf_raddr`/`dm_raddr` are registered. The read data is used combinationally in the same cycle as the beat.
- `rf_raddr` and `dm_raddr` are 0 outside their dump state.
- `halt` stays high from the trigger until reset.

## Test plan
- **Count limit:** `retire`=1 every cycle, PC = 0x3000, 0x3004, … (no repeats).
  - `halt` rises right after the 40th retire; `inst_count`=40, `halt_cause`=01.
  - 32 reg beats follow (beat 0 data 0 even with `rf_rdata`=0xDEADBEEF), then 2 mem beats at `dm_raddr` 80 and 84.
  - `done`=1 on the 35th cycle after halt.
- **Self-loop:** PC 0x3000, 0x3004, 0x3008, then 0x3008 ×4 → halt after the 7th retire; `inst_count`=7, `halt_cause`=10.
- **Bad PC:**
  - First retire with PC 0x2FFC → `halt_cause`=11, `inst_count`=1.
  - Separate run with PC 0x3002 → `halt_cause`=11.
- **Simultaneous causes:** 40th retire carries PC 0x4000+4·TEXT_WORDS → `halt_cause`=11 (bad PC wins). Separately, MAX_INST=0 with 100 distinct retires → no halt; `inst_count`=100.
- **Gapped retire:** `retire` high on alternate cycles for 80 cycles → halt after the 40th retire only; `inst_count`=40.
- **Reset mid-dump:** drop `rst` at reg beat 10 → all outputs 0 in the same cycle, no further beats. After release, the count-limit scenario reproduces its full 34-beat dump.
